// File: rtl/mem_stage_if.sv
// EX-to-MEM bus plus the MEM/WB results that leave the memory stage.
// The master side is the EX stage (or a bench) and the slave side is mem_stage.
interface mem_stage_if #(parameter int DATA_W = 16);
  logic [DATA_W-1:0] saidaULA;
  logic [DATA_W-1:0] dado2ALU_out;
  logic [2:0]        RD;
  logic [DATA_W-1:0] saidaSomador;
  logic              zeroEx;
  logic              MemRead_EX;
  logic              MemWrite_EX;
  logic              Branch_EX;
  logic              RegWrite_EX;
  logic              MemtoReg_EX;
  logic              flush;

  logic [DATA_W-1:0] resultadoALU_MEM;
  logic [2:0]        RD_MEM;
  logic              RegWrite_MEM;
  logic              PCSrc;
  logic [DATA_W-1:0] enderecoDesvio;
  logic [DATA_W-1:0] dadoLido_WB;
  logic [DATA_W-1:0] resultadoALU_WB;
  logic [2:0]        RD_WB;
  logic              RegWrite_WB;
  logic              MemtoReg_WB;

  modport master (
    output saidaULA, dado2ALU_out, RD, saidaSomador, zeroEx,
           MemRead_EX, MemWrite_EX, Branch_EX, RegWrite_EX, MemtoReg_EX, flush,
    input  resultadoALU_MEM, RD_MEM, RegWrite_MEM, PCSrc, enderecoDesvio,
           dadoLido_WB, resultadoALU_WB, RD_WB, RegWrite_WB, MemtoReg_WB
  );

  modport slave (
    input  saidaULA, dado2ALU_out, RD, saidaSomador, zeroEx,
           MemRead_EX, MemWrite_EX, Branch_EX, RegWrite_EX, MemtoReg_EX, flush,
    output resultadoALU_MEM, RD_MEM, RegWrite_MEM, PCSrc, enderecoDesvio,
           dadoLido_WB, resultadoALU_WB, RD_WB, RegWrite_WB, MemtoReg_WB
  );
endinterface

// File: rtl/mem_stage.sv
// Memory stage of the 16-bit pipeline: EX/MEM register, data memory, MEM/WB register.
// Branch resolution and forwarding taps are driven straight from EX/MEM.
module mem_stage #(
  parameter int DATA_W    = 16,
  parameter int ADDR_BITS = 8
) (
  input logic       clock,
  input logic       reset_n,
  mem_stage_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_W-1:0] aluMem;
  logic [DATA_W-1:0] storeDataMem;
  logic [2:0]        rdMem;
  logic [DATA_W-1:0] branchTargetMem;
  logic              zeroMem;
  logic              memReadMem;
  logic              memWriteMem;
  logic              branchMem;
  logic              regWriteMem;
  logic              memtoRegMem;

  logic [DATA_W-1:0] dadoLidoWb;
  logic [DATA_W-1:0] aluWb;
  logic [2:0]        rdWb;
  logic              regWriteWb;
  logic              memtoRegWb;

  logic [DATA_W-1:0] dataMem [DEPTH];
  logic [ADDR_BITS-1:0] memIdx;
  logic [DATA_W-1:0] readData;

  // Upper address bits are dropped, so accesses wrap modulo the memory depth.
  assign memIdx   = aluMem[ADDR_BITS-1:0];
  assign readData = dataMem[memIdx];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      aluMem          <= '0;
      storeDataMem    <= '0;
      rdMem           <= '0;
      branchTargetMem <= '0;
      zeroMem         <= 1'b0;
      memReadMem      <= 1'b0;
      memWriteMem     <= 1'b0;
      branchMem       <= 1'b0;
      regWriteMem     <= 1'b0;
      memtoRegMem     <= 1'b0;
      dadoLidoWb      <= '0;
      aluWb           <= '0;
      rdWb            <= '0;
      regWriteWb      <= 1'b0;
      memtoRegWb      <= 1'b0;
    end else begin
      aluMem          <= bus.saidaULA;
      storeDataMem    <= bus.dado2ALU_out;
      rdMem           <= bus.RD;
      branchTargetMem <= bus.saidaSomador;
      zeroMem         <= bus.zeroEx;
      // A flush turns the incoming instruction into a bubble but keeps its data fields.
      memReadMem      <= bus.MemRead_EX  & ~bus.flush;
      memWriteMem     <= bus.MemWrite_EX & ~bus.flush;
      branchMem       <= bus.Branch_EX   & ~bus.flush;
      regWriteMem     <= bus.RegWrite_EX & ~bus.flush;
      memtoRegMem     <= bus.MemtoReg_EX;

      dadoLidoWb      <= memReadMem ? readData : '0;
      aluWb           <= aluMem;
      rdWb            <= rdMem;
      regWriteWb      <= regWriteMem;
      memtoRegWb      <= memtoRegMem;
    end
  end

  // Array is not reset; a simultaneous read sees the pre-write word.
  always_ff @(posedge clock) begin
    if (reset_n && memWriteMem) begin
      dataMem[memIdx] <= storeDataMem;
    end
  end

  assign bus.resultadoALU_MEM = aluMem;
  assign bus.RD_MEM           = rdMem;
  assign bus.RegWrite_MEM     = regWriteMem;
  assign bus.PCSrc            = branchMem & zeroMem;
  assign bus.enderecoDesvio   = branchTargetMem;
  assign bus.dadoLido_WB      = dadoLidoWb;
  assign bus.resultadoALU_WB  = aluWb;
  assign bus.RD_WB            = rdWb;
  assign bus.RegWrite_WB      = regWriteWb;
  assign bus.MemtoReg_WB      = memtoRegWb;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, forwarding taps, loads/stores, wrap, branch, flush.
module tb_mem_stage;
  logic clock;
  logic reset_n;
  int total = 0;
  int bad   = 0;

  mem_stage_if #(.DATA_W(16)) bus ();

  mem_stage #(.DATA_W(16), .ADDR_BITS(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] allOut();
    return {6'd0, bus.resultadoALU_MEM, bus.RD_MEM, bus.RegWrite_MEM, bus.PCSrc,
            bus.enderecoDesvio, bus.dadoLido_WB, bus.resultadoALU_WB, bus.RD_WB,
            bus.RegWrite_WB, bus.MemtoReg_WB};
  endfunction

  task automatic bubble();
    bus.saidaULA     = '0;
    bus.dado2ALU_out = '0;
    bus.RD           = '0;
    bus.saidaSomador = '0;
    bus.zeroEx       = 1'b0;
    bus.MemRead_EX   = 1'b0;
    bus.MemWrite_EX  = 1'b0;
    bus.Branch_EX    = 1'b0;
    bus.RegWrite_EX  = 1'b0;
    bus.MemtoReg_EX  = 1'b0;
    bus.flush        = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic store(input logic [15:0] addr, input logic [15:0] data);
    bubble();
    bus.saidaULA     = addr;
    bus.dado2ALU_out = data;
    bus.MemWrite_EX  = 1'b1;
  endtask

  task automatic load(input logic [15:0] addr, input logic [2:0] rd);
    bubble();
    bus.saidaULA    = addr;
    bus.RD          = rd;
    bus.MemRead_EX  = 1'b1;
    bus.RegWrite_EX = 1'b1;
    bus.MemtoReg_EX = 1'b1;
  endtask

  initial begin
    bubble();
    reset_n = 1'b0;
    #12;
    check("reset_initial", allOut(), 80'd0);
    reset_n = 1'b1;
    #1;

    // Forwarding taps for a plain ALU instruction
    bubble();
    bus.saidaULA = 16'h00FF; bus.RD = 3'd3; bus.RegWrite_EX = 1'b1;
    step();
    check("alu_res_mem", 80'(bus.resultadoALU_MEM), 80'h00FF);
    check("alu_rd_mem",  80'(bus.RD_MEM), 80'd3);
    check("alu_rw_mem",  80'(bus.RegWrite_MEM), 80'd1);
    check("alu_pcsrc",   80'(bus.PCSrc), 80'd0);
    bubble();
    step();
    check("alu_wb", {32'd0, bus.resultadoALU_WB, bus.RD_WB, bus.RegWrite_WB, bus.MemtoReg_WB, bus.dadoLido_WB},
                    {32'd0, 16'h00FF, 3'd3, 1'b1, 1'b0, 16'h0000});

    // Store then back-to-back load of the same word
    store(16'h0005, 16'hBEEF);
    step();
    load(16'h0005, 3'd2);
    step();
    bubble();
    step();
    check("ld_data",  80'(bus.dadoLido_WB), 80'hBEEF);
    check("ld_ctl_wb", {bus.RD_WB, bus.RegWrite_WB, bus.MemtoReg_WB}, {3'd2, 1'b1, 1'b1});
    check("ld_alu_wb", 80'(bus.resultadoALU_WB), 80'h0005);

    // Address wrap-around
    store(16'h0103, 16'h1234);
    step();
    load(16'h0003, 3'd4);
    step();
    bubble();
    step();
    check("wrap_data", 80'(bus.dadoLido_WB), 80'h1234);

    // Branch resolution
    bubble();
    bus.Branch_EX = 1'b1; bus.zeroEx = 1'b1; bus.saidaSomador = 16'h0040;
    step();
    check("br_taken", {bus.PCSrc, bus.enderecoDesvio}, {1'b1, 16'h0040});
    bus.zeroEx = 1'b0; bus.saidaSomador = 16'h0080;
    step();
    check("br_not_taken", {bus.PCSrc, bus.enderecoDesvio}, {1'b0, 16'h0080});
    bus.zeroEx = 1'b1; bus.flush = 1'b1;
    step();
    check("br_flushed", 80'(bus.PCSrc), 80'd0);

    // Flushed store must not reach memory
    store(16'h0010, 16'h5555);
    step();
    store(16'h0010, 16'hAAAA);
    bus.RegWrite_EX = 1'b1; bus.flush = 1'b1;
    step();
    check("flush_rw_mem",  80'(bus.RegWrite_MEM), 80'd0);
    check("flush_alu_mem", 80'(bus.resultadoALU_MEM), 80'h0010);
    load(16'h0010, 3'd1);
    step();
    bubble();
    step();
    check("flush_mem_kept", 80'(bus.dadoLido_WB), 80'h5555);

    // Illegal read+write: write happens, read returns old word
    store(16'h0010, 16'h7777);
    bus.MemRead_EX = 1'b1;
    step();
    bubble();
    step();
    check("rw_old_data", 80'(bus.dadoLido_WB), 80'h5555);
    load(16'h0010, 3'd1);
    step();
    bubble();
    step();
    check("rw_new_data", 80'(bus.dadoLido_WB), 80'h7777);

    // Asynchronous reset in mid-period with in-flight instructions
    bubble();
    bus.saidaULA = 16'h00AB; bus.RD = 3'd5; bus.RegWrite_EX = 1'b1;
    bus.Branch_EX = 1'b1; bus.zeroEx = 1'b1; bus.saidaSomador = 16'h0C00;
    step();
    step();
    check("pre_reset_live", {bus.PCSrc, bus.RegWrite_WB}, {1'b1, 1'b1});
    #3;
    reset_n = 1'b0;
    #1;
    check("reset_async", allOut(), 80'd0);
    #1;
    reset_n = 1'b1;
    #1;
    check("reset_release_hold", allOut(), 80'd0);
    step();
    check("post_reset_capture", {bus.resultadoALU_MEM, bus.RD_MEM, bus.PCSrc},
                                {16'h00AB, 3'd5, 1'b1});

    // No write while reset is held across an edge
    store(16'h0010, 16'h9999);
    #2;
    reset_n = 1'b0;
    step();
    bubble();
    #2;
    reset_n = 1'b1;
    load(16'h0010, 3'd6);
    step();
    bubble();
    step();
    check("reset_no_write", 80'(bus.dadoLido_WB), 80'h7777);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
